// File: rtl/score_uart_formatter.sv
// score_uart_formatter: captures a 16-bit score, converts it to decimal and streams "<PREFIX><SEP>DDDDD\r\n" to a byte transmitter
//   CLK       in   system clock
//   RST       in   asynchronous active-high reset
//   START     in   frame request, honoured only when idle
//   SCORE     in   16-bit unsigned score, captured with START
//   TX_READY  in   transmitter ready
//   TX_SEND   out  one-cycle byte strobe
//   TX_DATA   out  byte presented to the transmitter
//   BUSY      out  frame in progress
//   DONE      out  one-cycle pulse when the last byte is accepted
module score_uart_formatter #(
    parameter logic [7:0] PREFIX = 8'h53,
    parameter logic [7:0] SEP    = 8'h3A
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] SCORE,
    input  logic        TX_READY,
    output logic        TX_SEND,
    output logic [7:0]  TX_DATA,
    output logic        BUSY,
    output logic        DONE
);
    typedef enum logic [1:0] {IDLE, CONVERT, ISSUE, WAIT} state_t;
    state_t state, state_nxt;
    logic [15:0] bin_q;
    logic [19:0] bcd_q, bcd_adj, bcd_sh;
    logic [4:0]  iter_q;
    logic [3:0]  idx_q, idx_nxt;
    logic [2:0]  dig_sel;
    logic [7:0]  byte_nxt;
    logic        last;
    // double-dabble add-3 correction on every nibble before the shift
    for (genvar n = 0; n < 5; n++) begin : g_adj
        assign bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] >= 4'd5 ? bcd_q[n*4 +: 4] + 4'd3 : bcd_q[n*4 +: 4];
    end
    assign idx_nxt  = idx_q + 4'd1;
    assign last     = idx_q == 4'd8;
    // bytes 2..6 map to nibbles 4..0, ten-thousands first
    assign dig_sel  = 3'(4'd6 - idx_nxt);
    assign bcd_sh   = bcd_q >> {dig_sel, 2'b00};
    assign byte_nxt = idx_nxt == 4'd1 ? SEP :
                      idx_nxt == 4'd7 ? 8'h0D :
                      idx_nxt == 4'd8 ? 8'h0A : {4'h3, bcd_sh[3:0]};
    assign BUSY     = state != IDLE;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        TX_SEND   = 1'b0;
        DONE      = 1'b0;
        case (state)
            IDLE:    state_nxt = START ? CONVERT : IDLE;
            CONVERT: state_nxt = iter_q == 5'd15 ? ISSUE : CONVERT;
            ISSUE: begin
                TX_SEND   = TX_READY;
                state_nxt = TX_READY ? WAIT : ISSUE;
            end
            default: begin
                DONE      = TX_READY && last;
                state_nxt = !TX_READY ? WAIT : last ? IDLE : ISSUE;
            end
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            idx_q   <= '0;
            TX_DATA <= '0;
        end else begin
            if (state == IDLE && START) begin
                bin_q  <= SCORE;
                bcd_q  <= '0;
                iter_q <= '0;
            end
            if (state == CONVERT) begin
                {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                iter_q         <= iter_q + 5'd1;
                if (iter_q == 5'd15) begin
                    idx_q   <= '0;
                    TX_DATA <= PREFIX;
                end
            end
            // TX_DATA only moves with the index, so it is stable for the whole ISSUE stretch
            if (state == WAIT && TX_READY && !last) begin
                idx_q   <= idx_nxt;
                TX_DATA <= byte_nxt;
            end
        end
    end
endmodule

// File: tb/tb_score_uart_formatter.sv
// tb_score_uart_formatter: randomized self-checking bench with a transmitter model and a decimal-arithmetic frame model
module tb_score_uart_formatter;
    logic        CLK = 0, RST = 1, START = 0, TX_READY;
    logic [15:0] SCORE = '0;
    logic        TX_SEND, BUSY, DONE;
    logic [7:0]  TX_DATA;
    int          errors = 0, checks = 0, cyc = 0, gap = 20, done_cnt = 0;
    bit          tx_busy = 0, stall = 0, prev_send = 0;
    logic [7:0]  got[$];
    int          send_cyc[$];
    logic [7:0]  exp_f[9];

    score_uart_formatter dut (
        .CLK(CLK), .RST(RST), .START(START), .SCORE(SCORE), .TX_READY(TX_READY),
        .TX_SEND(TX_SEND), .TX_DATA(TX_DATA), .BUSY(BUSY), .DONE(DONE)
    );

    assign TX_READY = !tx_busy && !stall;
    initial forever #5 CLK = ~CLK;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int s);
        int p;
        p = 10000;
        exp_f[0] = 8'h53;
        exp_f[1] = 8'h3A;
        for (int i = 0; i < 5; i++) begin
            exp_f[2 + i] = 8'(8'h30 + (s / p) % 10);
            p = p / 10;
        end
        exp_f[7] = 8'h0D;
        exp_f[8] = 8'h0A;
    endfunction

    // transmitter: READY falls the cycle after SEND and returns after gap cycles
    initial forever begin
        @(negedge CLK);
        if (TX_SEND && !RST) begin
            @(posedge CLK);
            #1 tx_busy = 1;
            repeat (gap) @(posedge CLK);
            #1 tx_busy = 0;
        end
    end

    initial forever begin
        @(negedge CLK);
        if (TX_SEND) begin
            check("send_ready", TX_READY, 1);
            check("send_back2back", prev_send, 0);
            got.push_back(TX_DATA);
            send_cyc.push_back(cyc);
        end
        if (DONE) begin
            done_cnt++;
            check("done_after_9", got.size(), 9);
        end
        prev_send = TX_SEND;
    end

    task automatic wait_idle_tx();
        for (int i = 0; i < 500 && tx_busy; i++) @(negedge CLK);
        check("tx_idle", tx_busy, 0);
    endtask

    // mode 0: plain frame, 1: READY held low at ISSUE entry, 2: second START mid-frame
    task automatic run_frame(input logic [15:0] s, input int g, input int mode);
        int t0, bad;
        gap = g;
        got.delete();
        send_cyc.delete();
        done_cnt = 0;
        model(int'(s));
        if (mode == 1) stall = 1;
        @(negedge CLK);
        START = 1;
        SCORE = s;
        @(negedge CLK);
        START = 0;
        t0 = cyc;
        SCORE = 16'($urandom);
        check("busy_after_start", BUSY, 1);
        if (mode == 1) begin
            repeat (16) @(negedge CLK);
            bad = 0;
            for (int i = 0; i < 50; i++) begin
                if (TX_SEND || TX_DATA != 8'h53) bad++;
                @(negedge CLK);
            end
            check("stall_hold", bad, 0);
            @(posedge CLK);
            #1 stall = 0;
            @(negedge CLK);
            check("stall_release", TX_SEND, 1);
        end
        if (mode == 2) begin
            for (int i = 0; i < 5000 && got.size() < 3; i++) @(negedge CLK);
            START = 1;
            SCORE = ~s;
            @(negedge CLK);
            START = 0;
        end
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        check("done_pulses", done_cnt, 1);
        check("busy_end", BUSY, 0);
        check("strobes", got.size(), 9);
        if (mode != 1 && send_cyc.size() > 0) check("latency", send_cyc[0] - t0 + 1, 17);
        for (int i = 0; i < 9 && i < got.size(); i++) check($sformatf("byte%0d_s%0d", i, s), got[i], exp_f[i]);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RST = 0;
        @(negedge CLK);
        check("rst_send", TX_SEND, 0);
        check("rst_data", TX_DATA, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        run_frame(16'd1234, 20, 0);
        run_frame(16'd65535, 20, 0);
        run_frame(16'd0, 20, 0);
        run_frame(16'd4096, 20, 1);
        run_frame(16'd9876, 20, 2);
        got.delete();
        gap = 20;
        @(negedge CLK);
        START = 1;
        SCORE = 16'd54321;
        @(negedge CLK);
        START = 0;
        for (int i = 0; i < 5000 && got.size() < 4; i++) @(negedge CLK);
        RST = 1;
        #1;
        check("rst_mid_send", TX_SEND, 0);
        check("rst_mid_busy", BUSY, 0);
        check("rst_mid_done", DONE, 0);
        check("rst_mid_data", TX_DATA, 0);
        repeat (5) @(negedge CLK);
        RST = 0;
        repeat (30) @(negedge CLK);
        check("rst_no_more_sends", got.size(), 4);
        wait_idle_tx();
        run_frame(16'd7, 20, 0);
        for (int k = 0; k < 6; k++) run_frame(16'($urandom), int'($urandom_range(1, 25)), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
